// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu -- byte/half/word load-store unit in front of a single-port,
// 32-bit wide RAM with combinational read data.
//
// Accepts one RISC-V style load or store at a time. Each accessed RAM word is
// handled in one cycle. Stores are done as a read-modify-write of that word.
// Loads are sign- or zero-extended. Every request, including a rejected one,
// ends with a one-cycle resp_valid pulse.
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   undefined : misaligned H/W requests are rejected with resp_err.
//   defined   : misaligned H/W requests are accepted. Accesses that cross a
//               word boundary use a second RAM cycle (state ACC1).
//
// Ports
//   clock, reset        sole clock; synchronous active-high reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_we, req_funct3  store/load select and RISC-V size/sign code
//   req_addr, req_wdata byte address and right-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata/resp_err extended load data / rejection flag (held)
//   mem_we, mem_addr,   RAM write enable, word address, write data
//   mem_wdata
//   mem_rdata           RAM combinational read data
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | ready for a request; decode and validate on handshake
// ACC0  | access word addr[AW+1:2] (RMW for stores, capture for loads)
// ACC1  | access the following word of a word-crossing request
// RESP  | resp_valid pulse, then back to IDLE
// ---------------------------------------------------------------------------
module mem_lsu #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [31:0] ld_q;          // load bytes gathered so far, right-aligned
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  // ---------------- request validation (IDLE) ----------------
  logic [31:0] req_word;
  logic        req_mis;
  logic        req_cross;
  logic        req_bad;

  always_comb begin
    req_word  = {2'b00, req_addr[31:2]};
    req_mis   = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
    // Only H at offset 3 or W at offset 1..3 spill into the next word.
    req_cross = ((req_funct3[1:0] == 2'd1) && (req_addr[1:0] == 2'd3)) ||
                ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
    req_bad   = 1'b0;
    if ((req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7))
      req_bad = 1'b1;
    if (req_we && req_funct3[2])
      req_bad = 1'b1;
    if (req_word >= DEPTH_W)
      req_bad = 1'b1;
    if (req_mis && !SPLIT_EN)
      req_bad = 1'b1;
    if (req_cross && ((req_word + 32'd1) >= DEPTH_W))
      req_bad = 1'b1;
  end

  // ---------------- lane mapping for the captured request ----------------
  logic [1:0]  off;
  logic [2:0]  nbytes;
  logic        acc_cross;
  logic [31:0] ld_d;          // ld_q with this cycle's lanes merged in

  assign off       = addr_q[1:0];
  assign nbytes    = (funct3_q[1:0] == 2'd0) ? 3'd1 :
                     (funct3_q[1:0] == 2'd1) ? 3'd2 : 3'd4;
  assign acc_cross = SPLIT_EN && ((int'(off) + int'(nbytes)) > 4);

  // RAM lane l holds request byte k = l - off in the first word and
  // k = l + 4 - off in the second word.
  always_comb begin : lane_map
    int base;
    int k;
    base      = (state_q == ACC1) ? 4 : 0;
    k         = 0;
    mem_wdata = mem_rdata;
    ld_d      = ld_q;
    for (int l = 0; l < 4; l++) begin
      k = l + base - int'(off);
      if ((k >= 0) && (k < int'(nbytes))) begin
        mem_wdata[8*l +: 8] = wdata_q[8*k +: 8];
        ld_d[8*k +: 8]      = mem_rdata[8*l +: 8];
      end
    end
  end

  function automatic logic [31:0] extend(input logic [31:0] d,
                                         input logic [2:0]  f3);
    case (f3)
      3'd0:    extend = {{24{d[7]}}, d[7:0]};
      3'd1:    extend = {{16{d[15]}}, d[15:0]};
      3'd4:    extend = {24'd0, d[7:0]};
      3'd5:    extend = {16'd0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // ---------------- RAM port ----------------
  assign mem_addr = (state_q == ACC1) ? (addr_q[AW+1:2] + AW'(1))
                                      : addr_q[AW+1:2];
  // Gated by reset so an access in flight never writes during reset.
  assign mem_we   = !reset && we_q && ((state_q == ACC0) || (state_q == ACC1));

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      ld_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q  <= ACC0;
              addr_q   <= req_addr;
              we_q     <= req_we;
              funct3_q <= req_funct3;
              wdata_q  <= req_wdata;
              ld_q     <= '0;
            end
          end
        end
        ACC0: begin
          ld_q <= ld_d;
          if (acc_cross) begin
            state_q <= ACC1;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? 32'd0 : extend(ld_d, funct3_q);
          end
        end
        ACC1: begin
          ld_q         <= ld_d;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? 32'd0 : extend(ld_d, funct3_q);
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
